// File: rtl/fft_frame_feeder.sv
// Ping-pong stereo frame buffer feeding a complex FFT core: left -> real lane, right -> imaginary lane.
// Optional Hann window on the output path when HANN_WINDOW_EN is defined (output latency 3 instead of 1).
module fft_frame_feeder #(
   parameter int N     = 2048,
   parameter int LOG2N = 11,
   parameter int W     = 18
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         s_valid,
   input  logic [W-1:0] s_left,
   input  logic [W-1:0] s_right,
   input  logic         fft_rfib,
   input  logic         fft_ibend,
   output logic         fft_ibstart,
   output logic [W-1:0] fft_dire,
   output logic [W-1:0] fft_diim,
   output logic         overrun,
   output logic         misalign,
   output logic [15:0]  frame_cnt
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_RDY = 2'd1,
      STREAM   = 2'd2
   } state_t;

   localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

   state_t           state_r;
   state_t           state_next_s;
   logic [2*W-1:0]   mem_r [2*N];
   logic [1:0]       full_r;
   logic [1:0]       full_next_s;
   logic             wr_bank_r;
   logic [LOG2N-1:0] wr_idx_r;
   logic             rd_bank_r;
   logic [LOG2N-1:0] rd_addr_r;
   logic             rd_en_s;
   logic             rd_first_s;
   logic             rd_last_s;
   logic             wr_accept_s;
   logic             wr_drop_s;
   logic [2*W-1:0]   rd_data_r;
   logic             start1_r;
   logic             last1_r;
   logic             last_out_s;
   logic             overrun_r;
   logic             misalign_r;
   logic [15:0]      frame_cnt_r;

   assign rd_first_s = rd_en_s && (rd_addr_r == {LOG2N{1'b0}});
   assign rd_last_s  = rd_en_s && (rd_addr_r == LAST_IDX);

   // A blocked writer may still land its sample in the bank the reader frees this very cycle.
   assign wr_accept_s = s_valid && (!full_r[wr_bank_r] || (rd_last_s && (rd_bank_r == wr_bank_r)));
   assign wr_drop_s   = s_valid && !wr_accept_s;

   // Reader FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Reader FSM next-state logic
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (full_r[rd_bank_r]) begin
               state_next_s = WAIT_RDY;
            end else begin
               state_next_s = IDLE;
            end
         end
         WAIT_RDY: begin
            if (fft_rfib) begin
               state_next_s = STREAM;
            end else begin
               state_next_s = WAIT_RDY;
            end
         end
         STREAM: begin
            if (rd_last_s) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = STREAM;
            end
         end
         default: state_next_s = IDLE;
      endcase
   end

   // Reader FSM outputs
   always_comb begin
      rd_en_s = 1'b0;
      case (state_r)
         STREAM:  rd_en_s = 1'b1;
         IDLE:    rd_en_s = 1'b0;
         WAIT_RDY: rd_en_s = 1'b0;
         default: rd_en_s = 1'b0;
      endcase
   end

   // Full-flag update: the reader's clear and the writer's set are both applied
   always_comb begin
      full_next_s = full_r;
      if (rd_last_s) begin
         full_next_s[rd_bank_r] = 1'b0;
      end else begin
         full_next_s[rd_bank_r] = full_r[rd_bank_r];
      end
      if (wr_accept_s && (wr_idx_r == LAST_IDX)) begin
         full_next_s[wr_bank_r] = 1'b1;
      end else begin
         full_next_s[wr_bank_r] = full_next_s[wr_bank_r];
      end
   end

   // Bank bookkeeping, writer/reader pointers and status flags
   always_ff @(posedge clk) begin
      if (rst) begin
         full_r      <= 2'b00;
         wr_bank_r   <= 1'b0;
         wr_idx_r    <= {LOG2N{1'b0}};
         rd_bank_r   <= 1'b0;
         rd_addr_r   <= {LOG2N{1'b0}};
         overrun_r   <= 1'b0;
         frame_cnt_r <= 16'd0;
      end else begin
         full_r <= full_next_s;
         if (wr_accept_s) begin
            wr_idx_r <= wr_idx_r + LOG2N'(1);
            if (wr_idx_r == LAST_IDX) begin
               wr_bank_r <= ~wr_bank_r;
            end
         end
         if (rd_en_s) begin
            rd_addr_r <= rd_addr_r + LOG2N'(1);
         end else begin
            rd_addr_r <= {LOG2N{1'b0}};
         end
         if (rd_last_s) begin
            rd_bank_r   <= ~rd_bank_r;
            frame_cnt_r <= frame_cnt_r + 16'd1;
         end
         if (wr_drop_s) begin
            overrun_r <= 1'b1;
         end
      end
   end

   // Sample RAM write port
   always_ff @(posedge clk) begin
      if (wr_accept_s) begin
         mem_r[{wr_bank_r, wr_idx_r}] <= {s_left, s_right};
      end
   end

   // Registered RAM read; zero outside a burst so the lanes idle at 0
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_r <= {(2*W){1'b0}};
         start1_r  <= 1'b0;
         last1_r   <= 1'b0;
      end else begin
         if (rd_en_s) begin
            rd_data_r <= mem_r[{rd_bank_r, rd_addr_r}];
         end else begin
            rd_data_r <= {(2*W){1'b0}};
         end
         start1_r <= rd_first_s;
         last1_r  <= rd_last_s;
      end
   end

`ifdef HANN_WINDOW_EN
   localparam logic signed [W+1:0] Q_MAX = (W+2)'((64'sd1 <<< (W-1)) - 64'sd1);
   localparam logic signed [W+1:0] Q_MIN = (W+2)'(-(64'sd1 <<< (W-1)));

   logic [W-1:0]        hann_rom_s [N/2];
   logic [LOG2N-2:0]    hann_idx_s;
   logic [W-1:0]        coef_r;
   logic signed [2*W:0] prod_re_r;
   logic signed [2*W:0] prod_im_r;
   logic                start2_r;
   logic                last2_r;
   logic                start3_r;
   logic                last3_r;
   logic [W-1:0]        win_re_r;
   logic [W-1:0]        win_im_r;

   // Round half-up at bit W, then saturate to a W-bit signed value.
   function automatic logic [W-1:0] round_sat(input logic signed [2*W:0] p);
      logic signed [2*W+1:0] r;
      logic signed [W+1:0]   q;
      r = (2*W+2)'(p) + ((2*W+2)'(1'b1) << (W-1));
      q = r[2*W+1:W];
      if (q > Q_MAX) begin
         return Q_MAX[W-1:0];
      end else if (q < Q_MIN) begin
         return Q_MIN[W-1:0];
      end else begin
         return q[W-1:0];
      end
   endfunction

   for (genvar k = 0; k < N/2; k++) begin : g_hann_rom
      localparam real ANG = 2.0 * 3.14159265358979323846 * $itor(k) / $itor(N);
      localparam logic [W-1:0] COEF =
         W'($rtoi((2.0**W - 1.0) * 0.5 * (1.0 - $cos(ANG)) + 0.5));
      assign hann_rom_s[k] = COEF;
   end

   // Only half the window is stored; the second half mirrors it (N-1-k == ~k).
   assign hann_idx_s = rd_addr_r[LOG2N-1] ? ~rd_addr_r[LOG2N-2:0] : rd_addr_r[LOG2N-2:0];

   // Coefficient fetch, aligned with the RAM read
   always_ff @(posedge clk) begin
      if (rst) begin
         coef_r <= {W{1'b0}};
      end else if (rd_en_s) begin
         coef_r <= hann_rom_s[hann_idx_s];
      end else begin
         coef_r <= {W{1'b0}};
      end
   end

   // Window multiply stage
   always_ff @(posedge clk) begin
      if (rst) begin
         prod_re_r <= {(2*W+1){1'b0}};
         prod_im_r <= {(2*W+1){1'b0}};
         start2_r  <= 1'b0;
         last2_r   <= 1'b0;
      end else begin
         prod_re_r <= (2*W+1)'($signed(rd_data_r[2*W-1:W])) * (2*W+1)'($signed({1'b0, coef_r}));
         prod_im_r <= (2*W+1)'($signed(rd_data_r[W-1:0])) * (2*W+1)'($signed({1'b0, coef_r}));
         start2_r  <= start1_r;
         last2_r   <= last1_r;
      end
   end

   // Round/saturate stage driving the FFT lanes
   always_ff @(posedge clk) begin
      if (rst) begin
         win_re_r <= {W{1'b0}};
         win_im_r <= {W{1'b0}};
         start3_r <= 1'b0;
         last3_r  <= 1'b0;
      end else begin
         win_re_r <= round_sat(prod_re_r);
         win_im_r <= round_sat(prod_im_r);
         start3_r <= start2_r;
         last3_r  <= last2_r;
      end
   end

   assign fft_dire    = win_re_r;
   assign fft_diim    = win_im_r;
   assign fft_ibstart = start3_r;
   assign last_out_s  = last3_r;
`else
   assign fft_dire    = rd_data_r[2*W-1:W];
   assign fft_diim    = rd_data_r[W-1:0];
   assign fft_ibstart = start1_r;
   assign last_out_s  = last1_r;
`endif

   // fft_ibend must coincide exactly with the cycle presenting the last sample
   always_ff @(posedge clk) begin
      if (rst) begin
         misalign_r <= 1'b0;
      end else if (fft_ibend != last_out_s) begin
         misalign_r <= 1'b1;
      end else begin
         misalign_r <= misalign_r;
      end
   end

   assign overrun   = overrun_r;
   assign misalign  = misalign_r;
   assign frame_cnt = frame_cnt_r;

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Scoreboard bench for fft_frame_feeder (default build, output latency 1): the stimulus pushes
// expected frames, a monitor compares each burst and plays the FFT's ibend handshake.
module tb_fft_frame_feeder;
   localparam int N     = 2048;
   localparam int LOG2N = 11;
   localparam int W     = 18;

   logic         clk = 1'b0;
   logic         rst;
   logic         s_valid;
   logic [W-1:0] s_left;
   logic [W-1:0] s_right;
   logic         fft_rfib;
   logic         fft_ibend;
   logic         fft_ibstart;
   logic [W-1:0] fft_dire;
   logic [W-1:0] fft_diim;
   logic         overrun;
   logic         misalign;
   logic [15:0]  frame_cnt;

   fft_frame_feeder #(.N(N), .LOG2N(LOG2N), .W(W)) dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_left(s_left), .s_right(s_right),
      .fft_rfib(fft_rfib), .fft_ibend(fft_ibend), .fft_ibstart(fft_ibstart),
      .fft_dire(fft_dire), .fft_diim(fft_diim), .overrun(overrun), .misalign(misalign),
      .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad = 0;
   logic [2*W-1:0] exp_q[$];
   int exp_frames = 0;
   int frames_seen = 0;
   int starts_seen = 0;
   int start_cyc = 0;
   int mon_k = 0;
   bit in_burst = 1'b0;
   bit inj_mid = 1'b0;
   bit suppress_end = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic logic [2*W-1:0] pair(input int v);
      logic [31:0] l;
      logic [31:0] r;
      l = v;
      r = -v;
      return {l[W-1:0], r[W-1:0]};
   endfunction

   task automatic push_frame(input int base);
      for (int k = 0; k < N; k++) exp_q.push_back(pair(base + k));
      exp_frames++;
   endtask

   task automatic send(input int base, input int count);
      for (int i = 0; i < count; i++) begin
         @(negedge clk);
         s_valid = 1'b1;
         {s_left, s_right} = pair(base + i);
      end
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   task automatic wait_frames(input int budget);
      int n = 0;
      while (frames_seen < exp_frames && n < budget) begin
         @(posedge clk);
         n++;
      end
      #2;
      chk("frame_arrival", frames_seen, exp_frames);
   endtask

   // Monitor: compares each burst against the queue and drives ibend like the FFT would.
   initial begin
      int err_k;
      logic [2*W-1:0] err_act;
      logic [2*W-1:0] err_exp;
      logic [2*W-1:0] e;
      forever begin
         @(posedge clk);
         #1;
         fft_ibend = 1'b0;
         if (fft_ibstart) begin
            starts_seen++;
            start_cyc = cyc;
            if (in_burst) chk("ibstart_mid_burst", mon_k, 0);
            if (exp_q.size() < N) begin
               chk("unexpected_frame", exp_q.size(), N);
               in_burst = 1'b0;
            end else begin
               in_burst = 1'b1;
               mon_k = 0;
               err_k = -1;
            end
         end
         if (in_burst) begin
            e = exp_q.pop_front();
            if ({fft_dire, fft_diim} !== e && err_k < 0) begin
               err_k = mon_k;
               err_act = {fft_dire, fft_diim};
               err_exp = e;
            end
            if (mon_k == 100 && inj_mid) fft_ibend = 1'b1;
            if (mon_k == N - 1) begin
               if (!suppress_end) fft_ibend = 1'b1;
               total++;
               if (err_k >= 0) begin
                  bad++;
                  $display("FAIL frame_data: sample %0d got %h expected %h", err_k, err_act, err_exp);
               end
               frames_seen++;
               in_burst = 1'b0;
            end
            mon_k++;
         end else begin
            chk("idle_lanes_zero", {fft_dire, fft_diim}, 0);
         end
      end
   end

   // Watchdog: the run must never hang.
   initial begin
      #900000;
      $display("FAIL watchdog: got cycle %0d expected completion", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int rise_cyc;
      int n;
      rst = 1'b1; s_valid = 1'b0; s_left = '0; s_right = '0;
      fft_rfib = 1'b0; fft_ibend = 1'b0;
      @(posedge clk); #2;
      chk("rst_ibstart", fft_ibstart, 0);
      chk("rst_dire", fft_dire, 0);
      chk("rst_diim", fft_diim, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_misalign", misalign, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Single frame, ready held high
      fft_rfib = 1'b1;
      push_frame(0);
      send(0, N);
      wait_frames(3000);
      chk("t1_starts", starts_seen, 1);
      chk("t1_frame_cnt", frame_cnt, 1);
      chk("t1_overrun", overrun, 0);
      chk("t1_misalign", misalign, 0);

      // Delayed ready: burst must wait for rfib, then start L+1 cycles later
      @(negedge clk);
      fft_rfib = 1'b0;
      push_frame(20000);
      send(20000, N);
      repeat (500) @(negedge clk);
      chk("t2_held_starts", starts_seen, 1);
      chk("t2_held_queue", exp_q.size(), N);
      fft_rfib = 1'b1;
      rise_cyc = cyc;
      wait_frames(3000);
      chk("t2_ibstart_latency", start_cyc - rise_cyc, 2);
      chk("t2_frame_cnt", frame_cnt, 2);

      // Overrun: both banks fill, extra samples are dropped
      @(negedge clk);
      fft_rfib = 1'b0;
      send(0, 2 * N);
      repeat (2) @(negedge clk);
      chk("t3_no_overrun_yet", overrun, 0);
      send(2 * N, 5);
      repeat (2) @(negedge clk);
      chk("t3_overrun", overrun, 1);
      chk("t3_frame_cnt_held", frame_cnt, 2);
      push_frame(0);
      push_frame(N);
      fft_rfib = 1'b1;
      wait_frames(6000);
      chk("t3_frame_cnt", frame_cnt, 4);
      chk("t3_misalign", misalign, 0);

      // Misalign: early ibend pulse at sample 100, then a clean frame keeps it sticky
      inj_mid = 1'b1;
      push_frame(5000);
      send(5000, N);
      wait_frames(3000);
      inj_mid = 1'b0;
      repeat (2) @(negedge clk);
      chk("t4_misalign", misalign, 1);
      push_frame(6000);
      send(6000, N);
      wait_frames(3000);
      repeat (2) @(negedge clk);
      chk("t4_misalign_sticky", misalign, 1);
      chk("t4_frame_cnt", frame_cnt, 6);

      // Reset mid-burst at sample 1000
      push_frame(7000);
      send(7000, N);
      n = 0;
      while (!(in_burst && mon_k >= 1000) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("t5_reached_mid_burst", (in_burst && mon_k >= 1000), 1);
      rst = 1'b1;
      exp_q.delete();
      exp_frames--;
      in_burst = 1'b0;
      mon_k = 0;
      @(posedge clk); #2;
      chk("t5_dire_zero", fft_dire, 0);
      chk("t5_diim_zero", fft_diim, 0);
      chk("t5_ibstart_zero", fft_ibstart, 0);
      chk("t5_frame_cnt", frame_cnt, 0);
      chk("t5_misalign_clr", misalign, 0);
      chk("t5_overrun_clr", overrun, 0);
      @(negedge clk);
      rst = 1'b0;
      n = starts_seen;
      repeat (30) @(negedge clk);
      chk("t5_idle_after_rst", starts_seen, n);
      push_frame(9000);
      send(9000, N);
      wait_frames(3000);
      chk("t5_fresh_frame_cnt", frame_cnt, 1);
      chk("t5_fresh_misalign", misalign, 0);

      // Missing ibend on the last sample
      suppress_end = 1'b1;
      push_frame(11000);
      send(11000, N);
      wait_frames(3000);
      suppress_end = 1'b0;
      repeat (2) @(negedge clk);
      chk("t6_missing_ibend", misalign, 1);
      chk("t6_frame_cnt", frame_cnt, 2);

      repeat (50) @(negedge clk);
      chk("queue_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
